counter: RTL and testbench
==========================

Name: counter

Overview:
- WIDTH-bit asynchronous (ripple) binary counter built from a chain of JK flip-flops.
- Stage 0 is clocked by the single system clock and driven by external J/K inputs. Each higher stage is a toggle-mode JK clocked by the previous stage's output.
- Used as a simple event/clock divider and counter. Provides true and complementary outputs.

Parameters:
- WIDTH, 4, number of flip-flop stages and counter width in bits (minimum 1).

Ports:
- clock  input   1      system clock; stage 0 samples on rising edge
- reset  input   1      asynchronous, active-high reset; clears all stages
- j      input   1      J input of stage 0
- k      input   1      K input of stage 0
- q      output  WIDTH  counter value; q[0] is LSB
- qb     output  WIDTH  bitwise complement of q at all times

Interface decision: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset:
  - While reset=1: q=0 and qb={WIDTH{1}}, immediately and independently of clock.
  - Reset deassertion takes effect on the next qualifying edge.
  - Reset asserted mid-count, including during a ripple, clears every stage at once.
- Stage 0, on rising edge of clock when reset=0 (standard JK):
  - j=0,k=0: hold.
  - j=0,k=1: q[0]<=0.
  - j=1,k=0: q[0]<=1.
  - j=1,k=1: q[0]<=~q[0].
- Stage i (1..WIDTH-1):
  - J=K=1 hardwired.
  - Toggles on the falling edge of q[i-1] (up-count ripple).
- Net effect per clock rising edge (with ripple settled):
  - jk=11: q <= q+1 mod 2^WIDTH; wraps from 2^WIDTH-1 to 0.
  - jk=10: q <= q|1, with no carry.
  - jk=01: if q[0]=1 then q <= q+1 mod 2^WIDTH (falling q[0] ripples a carry); else hold.
  - jk=00: hold.
- qb is combinationally ~q; no separate storage.
- Ripple timing:
  - Intermediate transient values are permitted during the ripple.
  - RTL uses zero-delay nonblocking updates; all stages settle within the same simulation timestep as the clock edge.
  - Bench samples at least 1 ns after the edge.
- No other inputs or handshakes; X on j/k propagates X to q[0].

Optional Feature:
- Macro COUNTER_DOWN_EN.
- Defined: stage i>0 toggles on the rising edge of q[i-1], so jk=11 gives q <= q-1 mod 2^WIDTH (0 wraps to 2^WIDTH-1).
  - jk=01 clears q[0]; no ripple occurs because a falling q[0] does not trigger the next stage.
  - jk=10: if q[0]=0 then q <= q-1 (rising q[0] ripples a borrow); else hold.
- Undefined: up-count behaviour as above.
- Reset behaviour identical in both builds.

Decomposition:
- Shared package counter_pkg:
  - default WIDTH constant (4).
  - 2-bit JK mode encoding constants: HOLD=00, RST=01, SET=10, TOG=11.
- One natural sub-module: jk_ff.
  - Ports: clk, reset (async active-high), j, k, q, qb.
  - Edge selected per instance; q resets to 0.
  - Instantiated WIDTH times via generate.
- Top level wires stage clocks from q[i-1] (inverted in up mode).

Test Plan:
- Reset asserted at t=0 with clock toggling -> q=0, qb=4'hF; no count while reset=1.
- Reset released, j=k=1, 4 rising clock edges -> q=4'd4, qb=4'hB.
- j=k=1 from q=0, 16 rising edges -> q passes 15 (qb=0), then wraps to 0 on the 16th.
- q=4, j=1,k=0, one edge -> q=5. Then j=0,k=1, one edge -> q=6. Another j=0,k=1 edge -> q stays 6.
- j=k=0 for 5 edges from q=6 -> q holds 6.
- Counting at q=7, assert reset between clock edges -> q=0 within the same timestep, without waiting for a clock edge.
- With COUNTER_DOWN_EN defined: reset, j=k=1, 1 edge -> q=4'hF; 3 more edges -> q=4'hC.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants for the ripple JK counter: default width, the stage-0
// J/K mode encoding and the JK characteristic equation.
package counter_pkg;

    localparam int COUNTER_WIDTH = 4;

    // Stage-0 {j,k} modes.
    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_RST  = 2'b01,
        JK_SET  = 2'b10,
        JK_TOG  = 2'b11
    } jk_mode_e;

    // Next state of a JK flip-flop: Q+ = J&~Q | ~K&Q.
    // Written as an expression rather than a case so that an X on j or k
    // reaches q instead of silently matching a default branch.
    function automatic logic jk_next(input logic j, input logic k, input logic q);
        return (j & ~q) | (~k & q);
    endfunction

endpackage

// File: rtl/counter_jk_ff.sv
// Single JK flip-flop with asynchronous active-high reset to 0.
// RISE selects the active clock edge (1 = rising, 0 = falling).
module jk_ff
    import counter_pkg::*;
#(
    parameter bit RISE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qb
);

    generate
        if (RISE) begin : g_rise
            // Rising-edge JK state update with asynchronous clear.
            // NOTE: non-blocking (<=) for flop state, so every stage sampling
            // on the same timestep sees pre-edge values; reset sits in the
            // sensitivity list because it must act without a clock edge.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) q <= 1'b0;
                else       q <= jk_next(j, k, q);
            end
        end else begin : g_fall
            // Falling-edge JK state update with asynchronous clear.
            always_ff @(negedge clk or posedge reset) begin
                if (reset) q <= 1'b0;
                else       q <= jk_next(j, k, q);
            end
        end
    endgenerate

    assign qb = ~q;

endmodule

// File: rtl/counter.sv
// WIDTH-bit ripple counter built from a chain of JK flip-flops.
// Stage 0 is clocked by the system clock and driven by j/k; each higher
// stage is a toggle flop clocked from the previous stage's output.
// Build option COUNTER_DOWN_EN: higher stages fire on the rising edge of
// the previous bit (down count); otherwise on its falling edge (up count).
module counter
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             j,
    input  logic             k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

    // Clock seen by each stage; stage 0 runs off the system clock.
    logic [WIDTH-1:0] stage_clk;
    logic [WIDTH-1:0] stage_q;
    logic [WIDTH-1:0] stage_qb;

    assign stage_clk[0] = clock;

    jk_ff #(.RISE(1'b1)) u_stage0 (
        .clk   (clock),
        .reset (reset),
        .j     (j),
        .k     (k),
        .q     (stage_q[0]),
        .qb    (stage_qb[0])
    );

    generate
        for (genvar i = 1; i < WIDTH; i++) begin : g_stage
`ifdef COUNTER_DOWN_EN
            // Rising edge of the lower bit ripples a borrow.
            assign stage_clk[i] = stage_q[i-1];
`else
            // Falling edge of the lower bit ripples a carry; inverting it lets
            // every stage use the same rising-edge flop.
            assign stage_clk[i] = ~stage_q[i-1];
`endif
            jk_ff #(.RISE(1'b1)) u_stage (
                .clk   (stage_clk[i]),
                .reset (reset),
                .j     (1'b1),
                .k     (1'b1),
                .q     (stage_q[i]),
                .qb    (stage_qb[i])
            );
        end
    endgenerate

    assign q  = stage_q;
    assign qb = stage_qb;

endmodule

// File: tb/tb_counter.sv
// Directed testbench for the ripple JK counter (WIDTH = 4).
// Covers the up-count build by default and the down-count build when
// COUNTER_DOWN_EN is defined.
module tb_counter;
    import counter_pkg::*;

    localparam int W = 4;

    logic         clock;
    logic         reset;
    logic         j;
    logic         k;
    logic [W-1:0] q;
    logic [W-1:0] qb;

    int total = 0;
    int bad   = 0;

    counter #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .j     (j),
        .k     (k),
        .q     (q),
        .qb    (qb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Wait n rising clock edges, then 1 ns so the ripple has settled.
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_jk(input jk_mode_e m);
        {j, k} = m;
    endtask

    // Pulse reset between clock edges.
    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        set_jk(JK_TOG);

        // Reset held across several edges: no counting.
        tick(3);
        check("rst_q", q, 4'h0);
        check("rst_qb", qb, 4'hF);

`ifndef COUNTER_DOWN_EN
        reset = 1'b0;
        tick(4);
        check("count4_q", q, 4'd4);
        check("count4_qb", qb, 4'hB);

        // Full wrap from 0.
        pulse_reset();
        check("clr_q", q, 4'd0);
        tick(15);
        check("count15_q", q, 4'd15);
        check("count15_qb", qb, 4'h0);
        tick(1);
        check("wrap_q", q, 4'd0);
        check("wrap_qb", qb, 4'hF);

        // Set / clear-with-carry / clear-hold from 4.
        tick(4);
        check("pre_set_q", q, 4'd4);
        set_jk(JK_SET);
        tick(1);
        check("set_q", q, 4'd5);
        set_jk(JK_RST);
        tick(1);
        check("rst_carry_q", q, 4'd6);
        tick(1);
        check("rst_hold_q", q, 4'd6);

        // Hold for 5 edges.
        set_jk(JK_HOLD);
        tick(5);
        check("hold_q", q, 4'd6);
        check("hold_qb", qb, 4'h9);

        // Set at q[0]=1 does not carry.
        set_jk(JK_TOG);
        tick(1);
        check("tog7_q", q, 4'd7);
        set_jk(JK_SET);
        tick(1);
        check("set_nocarry_q", q, 4'd7);

        // Mid-cycle async reset while counting.
        set_jk(JK_TOG);
        reset = 1'b1;
        #1;
        check("async_rst_q", q, 4'd0);
        check("async_rst_qb", qb, 4'hF);
        tick(1);
        check("rst_held_q", q, 4'd0);
        reset = 1'b0;
        tick(1);
        check("post_rst_q", q, 4'd1);
`else
        reset = 1'b0;
        tick(1);
        check("down1_q", q, 4'hF);
        check("down1_qb", qb, 4'h0);
        tick(3);
        check("down4_q", q, 4'hC);

        // Clear at q[0]=0 holds; set at q[0]=0 borrows.
        set_jk(JK_RST);
        tick(1);
        check("down_rst_hold_q", q, 4'hC);
        set_jk(JK_SET);
        tick(1);
        check("down_set_borrow_q", q, 4'hB);
        tick(1);
        check("down_set_hold_q", q, 4'hB);
        set_jk(JK_RST);
        tick(1);
        check("down_rst_q", q, 4'hA);

        set_jk(JK_HOLD);
        tick(5);
        check("down_hold_q", q, 4'hA);

        // Mid-cycle async reset.
        set_jk(JK_TOG);
        reset = 1'b1;
        #1;
        check("down_async_rst_q", q, 4'h0);
        check("down_async_rst_qb", qb, 4'hF);
        reset = 1'b0;
        tick(1);
        check("down_post_rst_q", q, 4'hF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
